// File: rtl/compound_rr_arbiter.sv
// Two-requester round-robin arbiter forwarding CompoundType payloads over a sync/notify handshake.
// Optional write-priority tie-break on contention is enabled by defining ARB_WRITE_PRIO_EN.

typedef enum logic {
   ModeRead  = 1'b0,
   ModeWrite = 1'b1
} compound_mode_e;

typedef struct packed {
   compound_mode_e mode;
   logic [15:0]    x;
   logic [15:0]    y;
} CompoundType;

module compound_rr_arbiter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  CompoundType       req0_in,
   input  logic              req0_in_sync,
   output logic              req0_in_notify,
   input  CompoundType       req1_in,
   input  logic              req1_in_sync,
   output logic              req1_in_notify,
   output CompoundType       arb_out,
   input  logic              arb_out_sync,
   output logic              arb_out_notify,
   output logic              grant_id,
   output logic [CNT_W-1:0]  grant_cnt0,
   output logic [CNT_W-1:0]  grant_cnt1
);

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StSend
   } state_e;

   localparam CompoundType ResetPayload = '{mode: ModeRead, x: 16'd0, y: 16'd0};

   state_e             state_q, state_d;
   logic               rr_ptr_q, rr_ptr_d;
   logic               gid_q, gid_d;
   logic               notify0_q, notify0_d;
   logic               notify1_q, notify1_d;
   logic               out_notify_q, out_notify_d;
   CompoundType        out_q, out_d;
   logic [CNT_W-1:0]   cnt0_q, cnt0_d;
   logic [CNT_W-1:0]   cnt1_q, cnt1_d;

   logic               pick1;
   logic               win_sync;
   CompoundType        win_data;

   // Winner when sampling in idle; only meaningful if at least one sync is high.
   always_comb begin
      pick1 = rr_ptr_q;
`ifdef ARB_WRITE_PRIO_EN
      if (req0_in.mode != req1_in.mode) begin
         pick1 = (req1_in.mode == ModeWrite);
      end
`endif
      if (!req0_in_sync) begin
         pick1 = 1'b1;
      end else if (!req1_in_sync) begin
         pick1 = 1'b0;
      end
   end

   assign win_sync = gid_q ? req1_in_sync : req0_in_sync;
   assign win_data = gid_q ? req1_in : req0_in;

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      gid_d        = gid_q;
      notify0_d    = 1'b0;
      notify1_d    = 1'b0;
      out_notify_d = out_notify_q;
      out_d        = out_q;
      cnt0_d       = cnt0_q;
      cnt1_d       = cnt1_q;

      unique case (state_q)
         StIdle: begin
            out_notify_d = 1'b0;
            if (req0_in_sync || req1_in_sync) begin
               gid_d     = pick1;
               notify0_d = !pick1;
               notify1_d = pick1;
               state_d   = StGrant;
            end
         end
         StGrant: begin
            if (win_sync) begin
               out_d        = win_data;
               out_notify_d = 1'b1;
               rr_ptr_d     = !gid_q;
               if (gid_q) begin
                  if (cnt1_q != {CNT_W{1'b1}}) cnt1_d = cnt1_q + CNT_W'(1);
               end else begin
                  if (cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + CNT_W'(1);
               end
               state_d = StSend;
            end else begin
               // Winner withdrew before the transfer: abandon without side effects.
               state_d = StIdle;
            end
         end
         StSend: begin
            if (arb_out_sync) begin
               out_notify_d = 1'b0;
               state_d      = StIdle;
            end
         end
         default: begin
            state_d      = StIdle;
            out_notify_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         rr_ptr_q     <= 1'b0;
         gid_q        <= 1'b0;
         notify0_q    <= 1'b0;
         notify1_q    <= 1'b0;
         out_notify_q <= 1'b0;
         out_q        <= ResetPayload;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         gid_q        <= gid_d;
         notify0_q    <= notify0_d;
         notify1_q    <= notify1_d;
         out_notify_q <= out_notify_d;
         out_q        <= out_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
      end
   end

   assign req0_in_notify = notify0_q;
   assign req1_in_notify = notify1_q;
   assign arb_out_notify = out_notify_q;
   assign arb_out        = out_q;
   assign grant_id       = gid_q;
   assign grant_cnt0     = cnt0_q;
   assign grant_cnt1     = cnt1_q;

endmodule

// File: tb/tb_compound_rr_arbiter.sv
// Directed self-checking bench for compound_rr_arbiter; covers the write-priority
// scenario as well when ARB_WRITE_PRIO_EN is defined.

module tb_compound_rr_arbiter;

   localparam int unsigned CNT_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   CompoundType       req0_in, req1_in;
   logic              req0_in_sync = 1'b0, req1_in_sync = 1'b0;
   logic              req0_in_notify, req1_in_notify;
   CompoundType       arb_out;
   logic              arb_out_sync = 1'b0;
   logic              arb_out_notify;
   logic              grant_id;
   logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;

   int errors = 0;
   int checks = 0;

   compound_rr_arbiter #(.CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .req0_in        (req0_in),
      .req0_in_sync   (req0_in_sync),
      .req0_in_notify (req0_in_notify),
      .req1_in        (req1_in),
      .req1_in_sync   (req1_in_sync),
      .req1_in_notify (req1_in_notify),
      .arb_out        (arb_out),
      .arb_out_sync   (arb_out_sync),
      .arb_out_notify (arb_out_notify),
      .grant_id       (grant_id),
      .grant_cnt0     (grant_cnt0),
      .grant_cnt1     (grant_cnt1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic CompoundType mk(input compound_mode_e m, input int x, input int y);
      CompoundType c;
      c.mode = m;
      c.x    = x[15:0];
      c.y    = y[15:0];
      return c;
   endfunction

   task automatic check_reset_state(input string tag);
      check({tag, "_n0"},   64'(req0_in_notify), 64'd0);
      check({tag, "_n1"},   64'(req1_in_notify), 64'd0);
      check({tag, "_on"},   64'(arb_out_notify), 64'd0);
      check({tag, "_out"},  64'(arb_out), 64'(mk(ModeRead, 0, 0)));
      check({tag, "_gid"},  64'(grant_id), 64'd0);
      check({tag, "_c0"},   64'(grant_cnt0), 64'd0);
      check({tag, "_c1"},   64'(grant_cnt1), 64'd0);
   endtask

   initial begin : main
      int order [8];
      int n_pulses;
      int overlap;
      int stall_bad;
      CompoundType held;

      req0_in = mk(ModeRead, 0, 0);
      req1_in = mk(ModeRead, 0, 0);
      #12;
      check_reset_state("por");
      rst = 1'b1;
      tick();

      // Single requester 1
      arb_out_sync = 1'b1;
      req1_in      = mk(ModeWrite, 42, 1);
      req1_in_sync = 1'b1;
      tick();
      check("single_n1",   64'(req1_in_notify), 64'd1);
      check("single_n0",   64'(req0_in_notify), 64'd0);
      check("single_on_t1", 64'(arb_out_notify), 64'd0);
      tick();
      req1_in_sync = 1'b0;
      check("single_n1_t2", 64'(req1_in_notify), 64'd0);
      check("single_out",  64'(arb_out), 64'(mk(ModeWrite, 42, 1)));
      check("single_gid",  64'(grant_id), 64'd1);
      check("single_on",   64'(arb_out_notify), 64'd1);
      check("single_c1",   64'(grant_cnt1), 64'd1);
      tick();
      check("single_on_t3", 64'(arb_out_notify), 64'd0);

      // Contention from a fresh reset: rr_ptr=0 so order is 0,1,0,1
      rst = 1'b0;
      #1;
      rst = 1'b1;
      req0_in      = mk(ModeRead, 100, 200);
      req1_in      = mk(ModeRead, 300, 400);
      req0_in_sync = 1'b1;
      req1_in_sync = 1'b1;
      n_pulses = 0;
      overlap  = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (req0_in_notify && req1_in_notify) overlap++;
         if (n_pulses < 8 && req0_in_notify) order[n_pulses++] = 0;
         if (n_pulses < 8 && req1_in_notify) order[n_pulses++] = 1;
      end
      req0_in_sync = 1'b0;
      req1_in_sync = 1'b0;
      check("cont_pulses",  64'(n_pulses), 64'd4);
      check("cont_order0",  64'(order[0]), 64'd0);
      check("cont_order1",  64'(order[1]), 64'd1);
      check("cont_order2",  64'(order[2]), 64'd0);
      check("cont_order3",  64'(order[3]), 64'd1);
      check("cont_overlap", 64'(overlap), 64'd0);
      check("cont_c0",      64'(grant_cnt0), 64'd2);
      check("cont_c1",      64'(grant_cnt1), 64'd2);
      check("cont_out",     64'(arb_out), 64'(mk(ModeRead, 300, 400)));

      // Downstream stall; a late request from 1 must be ignored while in SEND
      arb_out_sync = 1'b0;
      req0_in      = mk(ModeRead, 7, 9);
      req0_in_sync = 1'b1;
      tick();
      check("stall_n0", 64'(req0_in_notify), 64'd1);
      tick();
      req0_in_sync = 1'b0;
      req1_in_sync = 1'b1;
      check("stall_on", 64'(arb_out_notify), 64'd1);
      check("stall_c0", 64'(grant_cnt0), 64'd3);
      held      = arb_out;
      stall_bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (arb_out !== held || arb_out_notify !== 1'b1) stall_bad++;
         if (req0_in_notify || req1_in_notify) stall_bad++;
      end
      check("stall_hold", 64'(stall_bad), 64'd0);
      check("stall_data", 64'(held), 64'(mk(ModeRead, 7, 9)));
      arb_out_sync = 1'b1;
      tick();
      check("stall_done", 64'(arb_out_notify), 64'd0);

      // Protocol violation: requester 1 wins, then drops sync in GRANT
      tick();
      check("viol_n1", 64'(req1_in_notify), 64'd1);
      req1_in_sync = 1'b0;
      tick();
      check("viol_on", 64'(arb_out_notify), 64'd0);
      check("viol_c1", 64'(grant_cnt1), 64'd2);
      // Back in IDLE with rr_ptr still at 1: both pending, 1 must win again
      req0_in_sync = 1'b1;
      req1_in_sync = 1'b1;
      tick();
      check("viol_idle_n1", 64'(req1_in_notify), 64'd1);
      check("viol_idle_n0", 64'(req0_in_notify), 64'd0);
      tick();
      check("viol_send_gid", 64'(grant_id), 64'd1);
      check("viol_send_c1",  64'(grant_cnt1), 64'd3);
      check("viol_send_on",  64'(arb_out_notify), 64'd1);

      // Asynchronous reset while in SEND
      arb_out_sync = 1'b0;
      req0_in_sync = 1'b0;
      req1_in_sync = 1'b0;
      rst = 1'b0;
      #1;
      check_reset_state("midrst");
      #2;
      rst = 1'b1;
      tick();

`ifdef ARB_WRITE_PRIO_EN
      arb_out_sync = 1'b1;
      req0_in      = mk(ModeRead, 5, 6);
      req1_in      = mk(ModeWrite, 8, 9);
      req0_in_sync = 1'b1;
      req1_in_sync = 1'b1;
      tick();
      check("wprio_n1", 64'(req1_in_notify), 64'd1);
      tick();
      req1_in_sync = 1'b0;
      check("wprio_gid1", 64'(grant_id), 64'd1);
      check("wprio_out1", 64'(arb_out), 64'(mk(ModeWrite, 8, 9)));
      tick();
      tick();
      check("wprio_n0", 64'(req0_in_notify), 64'd1);
      tick();
      req0_in_sync = 1'b0;
      check("wprio_gid0", 64'(grant_id), 64'd0);
      check("wprio_c0",   64'(grant_cnt0), 64'd1);
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
